// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and load/store, issuing byte cycles.
// Build option MEM_ARB_RR_EN: alternate grants under contention instead of fixed MEM priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  typedef enum logic [1:0] {StIdle, StIfRd, StMemRd, StMemWr} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic              if_ok, pick_mem, more;
  logic [ADDR_W-1:0] next_a;
  logic [1:0]        lane, widx;
  logic [31:0]       captured;

`ifdef MEM_ARB_RR_EN
  logic last_mem_q, last_mem_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 3'd1;
    nbytes_d    = nbytes_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    ram_a_d     = '0;
    ram_dout_d  = '0;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_mem_d  = last_mem_q;
`endif

    // A fetch presented together with a flush is not a request.
    if_ok = if_req && !if_flush;
`ifdef MEM_ARB_RR_EN
    pick_mem = mem_req && !(if_ok && last_mem_q);
`else
    pick_mem = mem_req;
`endif

    more     = (cnt_q + 3'd1) < nbytes_q;
    next_a   = base_q + ADDR_W'(cnt_q + 3'd1);
    // Read data trails its address by one cycle, so lane = cnt - 1.
    lane     = cnt_q[1:0] - 2'd1;
    captured = buf_q | ({24'd0, ram_din} << {lane, 3'b000});
    widx     = cnt_q[1:0] + 2'd1;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // The done cycle is IDLE but must not grant.
        if (!if_done_q && !mem_done_q) begin
          if (pick_mem) begin
            state_d    = mem_we ? StMemWr : StMemRd;
            nbytes_d   = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;
            base_d     = mem_addr;
            wdata_d    = mem_wdata;
            buf_d      = '0;
            ram_a_d    = mem_addr;
            ram_wr_d   = mem_we;
            ram_dout_d = mem_we ? mem_wdata[7:0] : 8'd0;
`ifdef MEM_ARB_RR_EN
            last_mem_d = 1'b1;
`endif
          end else if (if_ok) begin
            state_d    = StIfRd;
            nbytes_d   = 3'd4;
            base_d     = if_addr;
            buf_d      = '0;
            ram_a_d    = if_addr;
`ifdef MEM_ARB_RR_EN
            last_mem_d = 1'b0;
`endif
          end
        end
      end
      StIfRd, StMemRd: begin
        if (state_q == StIfRd && if_flush) begin
          state_d = StIdle;
        end else begin
          if (cnt_q != 3'd0) buf_d = captured;
          if (more) ram_a_d = next_a;
          if (cnt_q == nbytes_q) begin
            state_d = StIdle;
            if (state_q == StIfRd) begin
              if_done_d  = 1'b1;
              if_rdata_d = captured;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = captured;
            end
          end
        end
      end
      StMemWr: begin
        if (more) begin
          ram_a_d    = next_a;
          ram_wr_d   = 1'b1;
          ram_dout_d = wdata_q[{widx, 3'b000} +: 8];
        end else begin
          state_d    = StIdle;
          mem_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_mem_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
`ifdef MEM_ARB_RR_EN
      last_mem_q  <= last_mem_d;
`endif
    end
  end

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;

endmodule
